// File: rtl/decode_stage_if.sv
// Bundle of fetch, register-file, write-back and execute-side signals
// around the instruction-decode stage. The decode stage uses the slave
// view; whatever surrounds it (the core or a bench) uses the master view.
interface decode_stage_if;
  // fetch -> decode handshake
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;

  // register-file read port
  logic [2:0]  rreg1;
  logic [2:0]  rreg2;
  logic [15:0] rd1;
  logic [15:0] rd2;

  // mirror of the register-file write port, used for bypass
  logic        wb_write;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;

  // execute-side control
  logic        flush;
  logic        ex_ready;

  // ID/EX pipeline register contents
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_funct;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic [15:0] ex_imm;
  logic [2:0]  ex_wreg;
  logic [15:0] ex_pc;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;
  logic        ex_illegal;

  // load-use stall statistics
  logic [15:0] stall_count;

  modport slave (
    input  if_valid, if_instr, if_pc,
    input  rd1, rd2,
    input  wb_write, wb_reg, wb_data,
    input  flush, ex_ready,
    output id_ready, rreg1, rreg2,
    output ex_valid, ex_op, ex_funct, ex_a, ex_b, ex_imm, ex_wreg, ex_pc,
    output ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal,
    output stall_count
  );

  modport master (
    output if_valid, if_instr, if_pc,
    output rd1, rd2,
    output wb_write, wb_reg, wb_data,
    output flush, ex_ready,
    input  id_ready, rreg1, rreg2,
    input  ex_valid, ex_op, ex_funct, ex_a, ex_b, ex_imm, ex_wreg, ex_pc,
    input  ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal,
    input  stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction-decode stage of the 16-bit MIPS core. Splits the fetched
// instruction into fields, drives the register-file read addresses,
// captures operands (with write-back bypass) into the ID/EX register and
// interlocks for one cycle on a load-use dependency.
module decode_stage (
  input  logic          clock,
  input  logic          reset,   // synchronous, active-low
  decode_stage_if.slave bus
);

  // Opcodes
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_J     = 4'h6;
  localparam logic [3:0] OP_NOP   = 4'h7;

  // Everything the ID/EX register carries
  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [2:0]  funct;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [2:0]  wreg;
    logic [15:0] pc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        illegal;
  } idex_t;

  idex_t       idex_q, idex_d;
  idex_t       dec;
  logic [15:0] stall_q, stall_d;

  // instruction fields
  logic [3:0]  op;
  logic [2:0]  rs, rt, rd, funct;
  logic [5:0]  imm6;
  logic [11:0] imm12;

  // which fields the incoming instruction really reads
  logic        use_rs, use_rt;
  logic        hazard, advance;

  assign op    = bus.if_instr[15:12];
  assign rs    = bus.if_instr[11:9];
  assign rt    = bus.if_instr[8:6];
  assign rd    = bus.if_instr[5:3];
  assign funct = bus.if_instr[2:0];
  assign imm6  = bus.if_instr[5:0];
  assign imm12 = bus.if_instr[11:0];

  // Register-file addresses come straight from the raw fields
  assign bus.rreg1 = rs;
  assign bus.rreg2 = rt;

  // Drops the instruction and clears every control bit; data fields are
  // left alone because nothing downstream looks at them without valid.
  function automatic idex_t kill(input idex_t x);
    idex_t r;
    r          = x;
    r.valid    = 1'b0;
    r.regwrite = 1'b0;
    r.memread  = 1'b0;
    r.memwrite = 1'b0;
    r.branch   = 1'b0;
    r.illegal  = 1'b0;
    return r;
  endfunction

  // Decode the instruction at fetch into a candidate ID/EX value
  always_comb begin
    dec        = '0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    dec.valid  = 1'b1;
    dec.op     = op;
    dec.funct  = funct;
    dec.pc     = bus.if_pc;
    dec.imm    = {{10{imm6[5]}}, imm6};
    // Write-back bypass: the register file may not have committed yet
    dec.a      = (bus.wb_write && (bus.wb_reg == rs)) ? bus.wb_data : bus.rd1;
    dec.b      = (bus.wb_write && (bus.wb_reg == rt)) ? bus.wb_data : bus.rd2;
    case (op)
      OP_RTYPE: begin
        use_rs       = 1'b1;
        use_rt       = 1'b1;
        dec.wreg     = rd;
        dec.regwrite = 1'b1;
      end
      OP_ADDI: begin
        use_rs       = 1'b1;
        dec.wreg     = rt;
        dec.regwrite = 1'b1;
      end
      OP_LW: begin
        use_rs       = 1'b1;
        dec.wreg     = rt;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
      end
      OP_SW: begin
        use_rs       = 1'b1;
        use_rt       = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        use_rs       = 1'b1;
        use_rt       = 1'b1;
        dec.branch   = 1'b1;
      end
      OP_J: begin
        dec.imm      = {4'h0, imm12};
        dec.branch   = 1'b1;
      end
      OP_NOP: begin
      end
      default: begin
        dec.illegal  = 1'b1;
      end
    endcase
  end

  // A load still in ID/EX whose target is read by the incoming instruction
  always_comb begin
    hazard = bus.if_valid && idex_q.valid && idex_q.memread &&
             ((use_rs && (idex_q.wreg == rs)) || (use_rt && (idex_q.wreg == rt)));
  end

  assign advance      = bus.ex_ready || !idex_q.valid;
  assign bus.id_ready = bus.flush || (!hazard && advance);

  // Next ID/EX value and stall counter, in priority order below reset
  always_comb begin
    idex_d  = idex_q;
    stall_d = stall_q;
    if (bus.flush) begin
      idex_d = kill(idex_q);
    end else if (advance) begin
      if (hazard || !bus.if_valid) begin
        idex_d = kill(idex_q);
      end else begin
        idex_d = dec;
      end
    end
    if (hazard && !bus.flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // ID/EX register and stall counter, cleared by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      idex_q  <= '0;
      stall_q <= '0;
    end else begin
      idex_q  <= idex_d;
      stall_q <= stall_d;
    end
  end

  assign bus.ex_valid    = idex_q.valid;
  assign bus.ex_op       = idex_q.op;
  assign bus.ex_funct    = idex_q.funct;
  assign bus.ex_a        = idex_q.a;
  assign bus.ex_b        = idex_q.b;
  assign bus.ex_imm      = idex_q.imm;
  assign bus.ex_wreg     = idex_q.wreg;
  assign bus.ex_pc       = idex_q.pc;
  assign bus.ex_regwrite = idex_q.regwrite;
  assign bus.ex_memread  = idex_q.memread;
  assign bus.ex_memwrite = idex_q.memwrite;
  assign bus.ex_branch   = idex_q.branch;
  assign bus.ex_illegal  = idex_q.illegal;
  assign bus.stall_count = stall_q;

endmodule
